fir_beat_sequencer: RTL and testbench

- Front-end controller for the dual-channel, 8-lane, decimate-by-8 FIR datapath.
- Accepts independent per-channel 8-lane AXI-stream beats and joins them into the filter's 256-bit input beat.
- Releases exactly a programmed number of data beats, then appends zero beats to drain the 120-tap delay line.
- Reports busy/done, so benches and the future capture/control logic can run filter bursts deterministically.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_lane_skid.sv | 53 +++++
 rtl/fir_beat_sequencer.sv | 135 +++++++++++++
 tb/tb_fir_beat_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, widths and sequencer state type for the dual-channel
// decimating FIR front end.
package fir_pkg;

  localparam int unsigned CHANNELS    = 2;
  localparam int unsigned DW          = 16;
  localparam int unsigned PSAMPLES    = 8;
  localparam int unsigned TAP_COUNT   = 120;
  localparam int unsigned FLUSH_BEATS = (TAP_COUNT + PSAMPLES - 1) / PSAMPLES;
  localparam int unsigned CNTW        = 16;
  localparam int unsigned CH_W        = PSAMPLES * DW;
  localparam int unsigned BEAT_W      = CHANNELS * CH_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } seq_state_t;

endpackage

// File: rtl/fir_lane_skid.sv
// Two-entry valid/ready FIFO holding one channel's lane beats until every
// channel has data to join.
module fir_lane_skid
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH = CH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  always_comb begin
    s_ready = (count != 2'd2);
    m_valid = (count != 2'd0);
    m_data  = mem[rd_ptr];
    push    = s_valid && s_ready;
    pop     = m_valid && m_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: rtl/fir_beat_sequencer.sv
// Joins per-channel lane beats into the FIR input beat, releases a fixed
// number of data beats, then appends zero beats to drain the delay line.
module fir_beat_sequencer
  import fir_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [CNTW-1:0]     cfg_len,
  output logic                busy,
  output logic                done,
  input  logic [CHANNELS-1:0] ch_tvalid,
  output logic [CHANNELS-1:0] ch_tready,
  input  logic [BEAT_W-1:0]   ch_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [BEAT_W-1:0]   m_tdata
);

  localparam logic [CNTW-1:0] FLUSH_N = CNTW'(FLUSH_BEATS);
  localparam logic [CNTW-1:0] ONE     = CNTW'(1);

  seq_state_t          state;
  logic [CNTW-1:0]     len;
  logic [CNTW-1:0]     out_cnt;
  logic [CNTW-1:0]     ld_cnt;
  logic [CNTW-1:0]     z_ld;
  logic [CNTW-1:0]     z_cnt;
  logic [CNTW-1:0]     in_cnt [CHANNELS];
  logic [CHANNELS-1:0] buf_ready;
  logic [CHANNELS-1:0] buf_valid;
  logic [CHANNELS-1:0] push;
  logic [CH_W-1:0]     buf_data [CHANNELS];
  logic [BEAT_W-1:0]   joined;
  logic                load_ok;
  logic                m_hs;
  logic                data_load;
  logic                zero_load;
  logic                last_data;
  logic                last_flush;

  always_comb begin
    ch_tready = '0;
    joined    = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      ch_tready[c]            = (state == RUN) && buf_ready[c] && (in_cnt[c] < len);
      joined[c*CH_W +: CH_W]  = buf_data[c];
    end
    push    = ch_tvalid & ch_tready;
    load_ok = !m_tvalid || m_tready;
    m_hs    = m_tvalid && m_tready;
    data_load = (state == RUN) && (&buf_valid) && load_ok;
    // Zero beats may load while still in RUN once every data beat has been
    // loaded, so the last data handshake is followed with no bubble.
    zero_load = (((state == RUN) && (ld_cnt == len)) || (state == FLUSH)) &&
                (z_ld < FLUSH_N) && load_ok;
    last_data  = (state == RUN) && m_hs && (out_cnt == len - ONE);
    last_flush = (state == FLUSH) && m_hs && (z_cnt == FLUSH_N - ONE);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    fir_lane_skid #(.WIDTH(CH_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .s_valid (push[c]),
      .s_ready (buf_ready[c]),
      .s_data  (ch_tdata[c*CH_W +: CH_W]),
      .m_valid (buf_valid[c]),
      .m_ready (data_load),
      .m_data  (buf_data[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      out_cnt  <= '0;
      ld_cnt   <= '0;
      z_ld     <= '0;
      z_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) in_cnt[c] <= '0;
    end else begin
      done <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (push[c]) in_cnt[c] <= in_cnt[c] + ONE;
      end
      if (data_load) ld_cnt <= ld_cnt + ONE;
      if (zero_load) z_ld   <= z_ld + ONE;

      if (data_load) begin
        m_tvalid <= 1'b1;
        m_tdata  <= joined;
      end else if (zero_load) begin
        m_tvalid <= 1'b1;
        m_tdata  <= '0;
      end else if (m_hs) begin
        m_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cfg_start) begin
            len     <= cfg_len;
            out_cnt <= '0;
            ld_cnt  <= '0;
            z_ld    <= '0;
            z_cnt   <= '0;
            busy    <= 1'b1;
            for (int unsigned c = 0; c < CHANNELS; c++) in_cnt[c] <= '0;
            state   <= (cfg_len != '0) ? RUN : FLUSH;
          end
        end
        RUN: begin
          if (m_hs)      out_cnt <= out_cnt + ONE;
          if (last_data) state   <= FLUSH;
        end
        FLUSH: begin
          if (m_hs) z_cnt <= z_cnt + ONE;
          if (last_flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_beat_sequencer.sv
// Table-driven burst bench with an output-beat scoreboard for fir_beat_sequencer.
module tb_fir_beat_sequencer;
  import fir_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_start;
  logic [CNTW-1:0]     cfg_len;
  logic                busy;
  logic                done;
  logic [CHANNELS-1:0] ch_tvalid;
  logic [CHANNELS-1:0] ch_tready;
  logic [BEAT_W-1:0]   ch_tdata;
  logic                m_tvalid;
  logic                m_tready;
  logic [BEAT_W-1:0]   m_tdata;

  always #5 clk = ~clk;

  fir_beat_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_len   (cfg_len),
    .busy      (busy),
    .done      (done),
    .ch_tvalid (ch_tvalid),
    .ch_tready (ch_tready),
    .ch_tdata  (ch_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata)
  );

  typedef struct {
    int         len;
    int         skew1;
    logic [3:0] rpat;
    int         mode;
    int         restart_at;
    int         abort_after;
    int         exp_beats;
    int         exp_done;
  } vec_t;

  vec_t              vecs [6];
  int                tests = 0;
  int                fails = 0;
  logic [BEAT_W-1:0] q [$];
  int                pop_cnt, done_cnt, first_pop, last_pop;
  int                mcyc = 0;
  bit                mon_en = 1'b0;
  bit                prev_stall = 1'b0;
  logic [BEAT_W-1:0] prev_data;

  task automatic check(input string name, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [CH_W-1:0] bd(input int mode, input int c, input int idx);
    logic [CH_W-1:0] d;
    d = '0;
    if (mode == 0) begin
      if (c == 0) d[DW-1:0] = 16'h7fff;
      else        d[CH_W-1 -: DW] = 16'h7fff;
    end else begin
      for (int k = 0; k < PSAMPLES; k++) d[k*DW +: DW] = 16'(32'h100 + idx*16 + c*8 + k);
    end
    return d;
  endfunction

  // Output monitor: scoreboard pop, stall stability and done timing.
  always @(negedge clk) begin
    logic [BEAT_W-1:0] exp_beat;
    mcyc++;
    if (rst || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", m_tdata, prev_data);
      end
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat: got %h expected none", m_tdata);
        end else begin
          exp_beat = q.pop_front();
          check("beat", m_tdata, exp_beat);
        end
        pop_cnt++;
        if (first_pop < 0) first_pop = mcyc;
        last_pop = mcyc;
      end
      if (done) begin
        done_cnt++;
        check("done_timing", {(mcyc == last_pop + 1), busy, (q.size() == 0)}, 3'b101);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  task automatic drive(input vec_t v, input int cyc, input int sent [CHANNELS], input int start_c [CHANNELS]);
    for (int c = 0; c < CHANNELS; c++) begin
      ch_tvalid[c] = (cyc >= start_c[c]);
      ch_tdata[c*CH_W +: CH_W] = bd(v.mode, c, sent[c]);
    end
    m_tready = v.rpat[cyc % 4];
  endtask

  task automatic run_vec(input vec_t v);
    int                  sent [CHANNELS];
    int                  start_c [CHANNELS];
    logic [CHANNELS-1:0] hs;
    int                  cyc, all_cyc, first_v, tail, budget;
    bit                  ready_seen, skew_done, aborted, timed_out, all;
    cyc = 0; all_cyc = -1; first_v = -1; tail = 0;
    ready_seen = 0; skew_done = 0; aborted = 0; timed_out = 1;
    budget = (v.len + 20) * 6 + 40;
    for (int c = 0; c < CHANNELS; c++) begin
      sent[c]    = 0;
      start_c[c] = (c == 1) ? v.skew1 : 0;
    end
    for (int i = 0; i < v.len; i++) q.push_back({bd(v.mode, 1, i), bd(v.mode, 0, i)});
    for (int i = 0; i < FLUSH_BEATS; i++) q.push_back('0);
    pop_cnt = 0; done_cnt = 0; first_pop = -1; last_pop = -1;

    @(posedge clk); #1;
    cfg_start = 1'b1;
    cfg_len   = 16'(v.len);
    drive(v, cyc, sent, start_c);
    while (cyc < budget) begin
      @(negedge clk);
      if (cyc == 1) check("busy_rise", busy, 1);
      hs = ch_tvalid & ch_tready;
      if (v.len == 0 && ch_tready != '0) ready_seen = 1;
      if (v.skew1 > 0 && !skew_done && sent[0] == 2 && sent[1] == 0) begin
        skew_done = 1;
        check("skew_ready0", ch_tready[0], 0);
      end
      if (first_v < 0 && m_tvalid) first_v = cyc;
      if (all_cyc < 0 && v.len > 0) begin
        all = 1;
        for (int c = 0; c < CHANNELS; c++) if (sent[c] + int'(hs[c]) == 0) all = 0;
        if (all) all_cyc = cyc;
      end
      @(posedge clk); #1;
      for (int c = 0; c < CHANNELS; c++) if (hs[c]) sent[c]++;
      cyc++;
      cfg_start = (v.restart_at > 0 && cyc == v.restart_at);
      if (cfg_start) cfg_len = 16'd5;
      if (v.abort_after > 0 && pop_cnt == v.abort_after) begin
        aborted   = 1;
        rst       = 1'b1;
        ch_tvalid = '0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ctrl", {busy, done, m_tvalid, ch_tready}, '0);
        check("abort_data", m_tdata, '0);
        q.delete();
        @(posedge clk); #1;
        rst       = 1'b0;
        timed_out = 0;
        break;
      end
      if (done_cnt > 0) begin
        tail++;
        if (tail == 3) begin
          timed_out = 0;
          break;
        end
      end
      drive(v, cyc, sent, start_c);
    end
    ch_tvalid = '0;
    cfg_start = 1'b0;
    if (timed_out) $display("FAIL timeout: got no completion within %0d cycles", budget);
    check("timeout", timed_out, 0);
    check("pop_count", pop_cnt, v.exp_beats);
    check("done_count", done_cnt, v.exp_done);
    check("busy_end", busy, 0);
    if (!aborted) check("queue_left", q.size(), 0);
    if (v.len > 0) check("latency", first_v - all_cyc, 2);
    if (v.rpat == 4'hF && !aborted) check("no_bubble", last_pop - first_pop, v.exp_beats - 1);
    if (v.len == 0) check("zero_len_ready", ready_seen, 0);
    q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no summary expected summary");
    $fatal(1, "global timeout");
  end

  initial begin
    vecs[0] = '{len:4,  skew1:0, rpat:4'b1111, mode:0, restart_at:0, abort_after:0, exp_beats:19, exp_done:1};
    vecs[1] = '{len:3,  skew1:6, rpat:4'b1111, mode:1, restart_at:0, abort_after:0, exp_beats:18, exp_done:1};
    vecs[2] = '{len:8,  skew1:0, rpat:4'b1001, mode:1, restart_at:0, abort_after:0, exp_beats:23, exp_done:1};
    vecs[3] = '{len:0,  skew1:0, rpat:4'b1111, mode:1, restart_at:5, abort_after:0, exp_beats:15, exp_done:1};
    vecs[4] = '{len:10, skew1:0, rpat:4'b1111, mode:1, restart_at:0, abort_after:2, exp_beats:2,  exp_done:0};
    vecs[5] = '{len:2,  skew1:0, rpat:4'b1111, mode:1, restart_at:0, abort_after:0, exp_beats:17, exp_done:1};

    rst = 1'b1; cfg_start = 1'b0; cfg_len = '0;
    ch_tvalid = '0; ch_tdata = '0; m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cfg_start = 1'($urandom_range(0, 1));
      cfg_len   = 16'($urandom);
      ch_tvalid = 2'($urandom);
      ch_tdata  = {8{$urandom()}};
      m_tready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_ctrl", {busy, done, m_tvalid, ch_tready}, '0);
      check("rst_data", m_tdata, '0);
      check("rst_state", dut.state, IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ch_tvalid = 2'($urandom);
      m_tready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_ready", {busy, ch_tready}, '0);
      @(posedge clk); #1;
    end
    ch_tvalid = '0;
    m_tready  = 1'b1;
    mon_en    = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
